// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and defaults for the MIPS pipeline hazard/stall control.
// Pure declarations; no logic, no latency.
package mips_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int DEF_MULT_CYCLES = 4;
   localparam int DEF_DIV_CYCLES  = 32;
   localparam int DEF_CNT_W       = 6;
   localparam int DEF_PERF_W      = 16;

   // $zero is hard-wired, so a match on it is never a real dependency.
   function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != REG_ZERO) && (src == dst);
   endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mult/div sequencer: IDLE -> BUSY (N cycles) -> DONE (hilo_we) -> IDLE.
// md_start is registered (first BUSY cycle); issue is refused while hazard is high or not IDLE.
module md_sequencer
   import mips_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_md_op,
   input  logic i_md_div,
   input  logic i_hazard,
   output logic o_md_start,
   output logic o_md_busy,
   output logic o_hilo_we
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

   generate
      if ((MULT_CYCLES < 1) || (MULT_CYCLES > (1 << CNT_W))) begin : g_bad_mult
         $error("md_sequencer: MULT_CYCLES out of range for CNT_W");
      end
      if ((DIV_CYCLES < 1) || (DIV_CYCLES > (1 << CNT_W))) begin : g_bad_div
         $error("md_sequencer: DIV_CYCLES out of range for CNT_W");
      end
   endgenerate

   md_state_t        r_state;
   md_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_md_start;
   logic             w_issue;

   assign w_issue = i_md_op & (r_state == ST_IDLE) & ~i_hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_md_start <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_md_start <= w_issue;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = i_md_div ? DIV_LD : MULT_LD;
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      o_md_start = r_md_start;
      o_md_busy  = (r_state != ST_IDLE);
      o_hilo_we  = (r_state == ST_DONE);
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard stall/flush control for the 5-stage MIPS pipe plus mult/div sequencing and stall counter.
// Stall/flush are combinational from decode/EX/MEM fields; md_start/hilo_we/perf count are registered.
module pipe_stall_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int PERF_W      = DEF_PERF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        rs_d,
   input  logic [4:0]        rt_d,
   input  logic              branch_d,
   input  logic              pcsrc_d,
   input  logic              md_op_d,
   input  logic              md_div_d,
   input  logic              mfhilo_d,
   input  logic              memtoreg_e,
   input  logic              regwrite_e,
   input  logic [4:0]        writereg_e,
   input  logic              memtoreg_m,
   input  logic [4:0]        writereg_m,
   input  logic              perf_clr,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic              md_start,
   output logic              md_busy,
   output logic              hilo_we,
   output logic [PERF_W-1:0] perf_stall_cnt
);

   logic              w_hit_e;
   logic              w_hit_m;
   logic              w_lwstall;
   logic              w_brstall;
   logic              w_mdstall;
   logic              w_stall;
   logic              w_md_busy;
   logic [PERF_W-1:0] r_perf_cnt;

   assign w_hit_e = reg_hit(rs_d, writereg_e) | reg_hit(rt_d, writereg_e);
   assign w_hit_m = reg_hit(rs_d, writereg_m) | reg_hit(rt_d, writereg_m);

   // Branch operands are compared in decode, so any in-flight producer not yet forwardable blocks it.
   assign w_lwstall = memtoreg_e & w_hit_e;
   assign w_brstall = branch_d & ((regwrite_e & w_hit_e) | (memtoreg_m & w_hit_m));
   assign w_mdstall = w_md_busy & (md_op_d | mfhilo_d);
   assign w_stall   = w_lwstall | w_brstall | w_mdstall;

   assign stall_f = w_stall;
   assign stall_d = w_stall;
   assign flush_e = w_stall;
   assign flush_d = pcsrc_d & ~w_stall;

   md_sequencer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_md_op    (md_op_d),
      .i_md_div   (md_div_d),
      .i_hazard   (w_lwstall | w_brstall),
      .o_md_start (md_start),
      .o_md_busy  (w_md_busy),
      .o_hilo_we  (hilo_we)
   );

   assign md_busy = w_md_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_cnt <= '0;
      end else if (perf_clr) begin
         r_perf_cnt <= '0;
      end else if (w_stall && (r_perf_cnt != '1)) begin
         r_perf_cnt <= r_perf_cnt + 1'b1;
      end
   end

   assign perf_stall_cnt = r_perf_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: per-cycle expected outputs from a timestamp model,
// md_start/hilo_we pulses scheduled into queues at issue time and consumed when due.
module tb_pipe_stall_ctrl;

   localparam int MULT   = 4;
   localparam int DIV    = 32;
   localparam int PERF_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [4:0]        rs_d, rt_d, writereg_e, writereg_m;
   logic              branch_d, pcsrc_d, md_op_d, md_div_d, mfhilo_d;
   logic              memtoreg_e, regwrite_e, memtoreg_m, perf_clr;
   logic              stall_f, stall_d, flush_d, flush_e;
   logic              md_start, md_busy, hilo_we;
   logic [PERF_W-1:0] perf_stall_cnt;

   pipe_stall_ctrl #(
      .MULT_CYCLES (MULT),
      .DIV_CYCLES  (DIV),
      .CNT_W       (6),
      .PERF_W      (PERF_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rs_d           (rs_d),
      .rt_d           (rt_d),
      .branch_d       (branch_d),
      .pcsrc_d        (pcsrc_d),
      .md_op_d        (md_op_d),
      .md_div_d       (md_div_d),
      .mfhilo_d       (mfhilo_d),
      .memtoreg_e     (memtoreg_e),
      .regwrite_e     (regwrite_e),
      .writereg_e     (writereg_e),
      .memtoreg_m     (memtoreg_m),
      .writereg_m     (writereg_m),
      .perf_clr       (perf_clr),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .md_start       (md_start),
      .md_busy        (md_busy),
      .hilo_we        (hilo_we),
      .perf_stall_cnt (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              stall;
      logic              flush_d;
      logic              busy;
      logic [PERF_W-1:0] perf;
   } exp_t;

   exp_t              q_exp[$];
   int                q_start[$];
   int                q_hilo[$];
   int                n_checks = 0;
   int                n_fail   = 0;
   int                cyc      = 0;
   int                busy_until = -1;
   logic [PERF_W-1:0] perf_m = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   task automatic idle_in();
      rs_d = 5'd0; rt_d = 5'd0; writereg_e = 5'd0; writereg_m = 5'd0;
      branch_d = 1'b0; pcsrc_d = 1'b0; md_op_d = 1'b0; md_div_d = 1'b0;
      mfhilo_d = 1'b0; memtoreg_e = 1'b0; regwrite_e = 1'b0; memtoreg_m = 1'b0;
      perf_clr = 1'b0;
   endtask

   task automatic cyc_begin();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Inputs for this cycle are already driven; predict, sample at negedge, then advance the model.
   task automatic cyc_end();
      exp_t e;
      logic lw, br, busy, st, iss, exp_start, exp_hilo;
      int   n;
      if (!rst_n) begin
         busy_until = -1;
         q_start.delete();
         q_hilo.delete();
         perf_m = '0;
      end
      lw   = memtoreg_e & (hit(rs_d, writereg_e) | hit(rt_d, writereg_e));
      br   = branch_d & ((regwrite_e & (hit(rs_d, writereg_e) | hit(rt_d, writereg_e))) |
                         (memtoreg_m & (hit(rs_d, writereg_m) | hit(rt_d, writereg_m))));
      busy = rst_n && (cyc <= busy_until);
      st   = lw | br | (busy & (md_op_d | mfhilo_d));
      iss  = rst_n & md_op_d & ~busy & ~lw & ~br;
      e.stall   = st;
      e.flush_d = pcsrc_d & ~st;
      e.busy    = busy;
      e.perf    = perf_m;
      q_exp.push_back(e);

      @(negedge clk);
      e = q_exp.pop_front();
      exp_start = (q_start.size() > 0) && (q_start[0] == cyc);
      if (exp_start) void'(q_start.pop_front());
      exp_hilo = (q_hilo.size() > 0) && (q_hilo[0] == cyc);
      if (exp_hilo) void'(q_hilo.pop_front());
      check_eq("stall_f", 32'(stall_f), 32'(e.stall));
      check_eq("stall_d", 32'(stall_d), 32'(e.stall));
      check_eq("flush_e", 32'(flush_e), 32'(e.stall));
      check_eq("flush_d", 32'(flush_d), 32'(e.flush_d));
      check_eq("md_busy", 32'(md_busy), 32'(e.busy));
      check_eq("md_start", 32'(md_start), 32'(exp_start));
      check_eq("hilo_we", 32'(hilo_we), 32'(exp_hilo));
      check_eq("perf_cnt", 32'(perf_stall_cnt), 32'(e.perf));

      if (rst_n) begin
         if (iss) begin
            n = md_div_d ? DIV : MULT;
            busy_until = cyc + n + 1;
            q_start.push_back(cyc + 1);
            q_hilo.push_back(cyc + n + 1);
         end
         if (perf_clr) perf_m = '0;
         else if (st && (perf_m != '1)) perf_m = perf_m + 1'b1;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_begin(); idle_in(); cyc_end();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_in();
      repeat (3) begin cyc_begin(); cyc_end(); end
      cyc_begin(); rst_n = 1'b1; cyc_end();

      // Load-use and $zero
      cyc_begin(); idle_in(); memtoreg_e = 1'b1; writereg_e = 5'd8; rs_d = 5'd8; cyc_end();
      idle_cycles(1);
      cyc_begin(); idle_in(); memtoreg_e = 1'b1; writereg_e = 5'd0; rs_d = 5'd0; cyc_end();
      cyc_begin(); idle_in(); memtoreg_e = 1'b1; writereg_e = 5'd5; rt_d = 5'd5; cyc_end();
      cyc_begin(); idle_in(); regwrite_e = 1'b1; writereg_e = 5'd5; rs_d = 5'd5; cyc_end();

      // Decode-stage branch hazards
      cyc_begin(); idle_in(); branch_d = 1'b1; pcsrc_d = 1'b1; regwrite_e = 1'b1;
      writereg_e = 5'd9; rt_d = 5'd9; cyc_end();
      cyc_begin(); idle_in(); branch_d = 1'b1; pcsrc_d = 1'b1; regwrite_e = 1'b1;
      writereg_e = 5'd3; rt_d = 5'd9; cyc_end();
      cyc_begin(); idle_in(); branch_d = 1'b1; memtoreg_m = 1'b1; writereg_m = 5'd12;
      rs_d = 5'd12; pcsrc_d = 1'b1; cyc_end();
      cyc_begin(); idle_in(); branch_d = 1'b1; writereg_m = 5'd12; rs_d = 5'd12;
      pcsrc_d = 1'b1; cyc_end();
      cyc_begin(); idle_in(); branch_d = 1'b1; regwrite_e = 1'b1; pcsrc_d = 1'b1; cyc_end();

      // Load-use blocks an md issue, then multiply issues alongside a redirect
      cyc_begin(); idle_in(); md_op_d = 1'b1; memtoreg_e = 1'b1; writereg_e = 5'd4;
      rs_d = 5'd4; cyc_end();
      cyc_begin(); idle_in(); md_op_d = 1'b1; pcsrc_d = 1'b1; cyc_end();
      for (int i = 0; i < 7; i++) begin
         cyc_begin(); idle_in(); mfhilo_d = 1'b1; cyc_end();
      end
      idle_cycles(2);

      // Divide; a multiply arriving in DONE waits one cycle then issues
      cyc_begin(); idle_in(); md_op_d = 1'b1; md_div_d = 1'b1; cyc_end();
      idle_cycles(DIV);
      cyc_begin(); idle_in(); md_op_d = 1'b1; cyc_end();
      cyc_begin(); idle_in(); md_op_d = 1'b1; cyc_end();
      idle_cycles(MULT + 3);

      // Reset in the third BUSY cycle of a divide
      cyc_begin(); idle_in(); md_op_d = 1'b1; md_div_d = 1'b1; cyc_end();
      idle_cycles(2);
      cyc_begin(); idle_in(); rst_n = 1'b0; cyc_end();
      cyc_begin(); idle_in(); cyc_end();
      cyc_begin(); idle_in(); rst_n = 1'b1; cyc_end();
      idle_cycles(DIV + 6);

      // Stall counter saturation and clear priority
      for (int i = 0; i < 20; i++) begin
         cyc_begin(); idle_in(); memtoreg_e = 1'b1; writereg_e = 5'd7; rt_d = 5'd7; cyc_end();
      end
      cyc_begin(); idle_in(); memtoreg_e = 1'b1; writereg_e = 5'd7; rt_d = 5'd7;
      perf_clr = 1'b1; cyc_end();
      idle_cycles(1);
      cyc_begin(); idle_in(); memtoreg_e = 1'b1; writereg_e = 5'd7; rs_d = 5'd7; cyc_end();
      idle_cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
